if_id_decode: RTL

Fetch-to-decode pipeline register with early immediate decode for the exception-capable pipelined MIPS core. It captures the fetched instruction and PC+4 and pre-decodes the instruction into the immediate fields and `ExtOp` control consumed by the immediate extender in ID. It also carries fetch-stage exception state, detects reserved instructions and `eret`, and honours stall and flush from the hazard and exception units.

---
 rtl/if_id_decode_pkg.sv | 33 +++
 rtl/if_id_decode_if.sv | 18 +
 rtl/if_id_decode_predecode.sv | 38 +++
 rtl/if_id_decode.sv | 65 ++++++
 4 files changed

// File: rtl/if_id_decode_pkg.sv
// mips_defs: opcode/funct constants, extender modes and exception codes shared by the ID stage
package mips_defs;
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO  = 6'h12, FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV   = 6'h1A, FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB   = 6'h22, FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR   = 6'h26, FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;
   localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
   localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
   localparam logic [4:0] EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_RI = 5'd10;
   localparam logic [31:0] ERET_WORD = 32'h4200_0018;

   typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_SHAMT = 2'b10} ext_op_e;

   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
         FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
         FN_SLT, FN_SLTU: funct_ok = 1'b1;
         default:         funct_ok = 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/if_id_decode_if.sv
// if_id_decode_if: fetch-side inputs and ID-stage outputs of the IF/ID register
interface if_id_decode_if;
   logic [31:0] Instr_F, PC4_F, Instr_D, PC4_D;
   logic [4:0]  ExcCode_F, ExcCode_D, Rs_D, Rt_D, Rd_D;
   logic        BD_F, Stall, Flush, BD_D, Eret_D, Valid_D;
   logic [15:0] Imm16_D;
   logic [25:0] Imm26_D;
   logic [1:0]  ExtOp_D;

   modport master (
      output Instr_F, PC4_F, ExcCode_F, BD_F, Stall, Flush,
      input  Instr_D, PC4_D, Imm16_D, Imm26_D, ExtOp_D, Rs_D, Rt_D, Rd_D, ExcCode_D, BD_D, Eret_D, Valid_D
   );
   modport slave (
      input  Instr_F, PC4_F, ExcCode_F, BD_F, Stall, Flush,
      output Instr_D, PC4_D, Imm16_D, Imm26_D, ExtOp_D, Rs_D, Rt_D, Rd_D, ExcCode_D, BD_D, Eret_D, Valid_D
   );
endinterface

// File: rtl/if_id_decode_predecode.sv
// instr_predecode: combinational extender-mode, reserved-instruction and eret detection
module instr_predecode
   import mips_defs::*;
(
   input  logic [31:0] i_instr,
   output ext_op_e     o_ext_op,
   output logic        o_ri,
   output logic        o_eret
);
   logic [5:0] w_op, w_funct;
   logic [4:0] w_rs, w_rt;
   assign w_op    = i_instr[31:26];
   assign w_rs    = i_instr[25:21];
   assign w_rt    = i_instr[20:16];
   assign w_funct = i_instr[5:0];
   assign o_eret  = i_instr == ERET_WORD;

   always_comb begin
      o_ext_op = EXT_ZERO;
      o_ri     = 1'b0;
      case (w_op)
         OP_SPECIAL: begin
            o_ext_op = (w_funct == FN_SLL || w_funct == FN_SRL || w_funct == FN_SRA) ? EXT_SHAMT : EXT_ZERO;
            o_ri     = !funct_ok(w_funct);
         end
         OP_REGIMM: begin
            o_ext_op = EXT_SIGN;
            o_ri     = w_rt != RT_BLTZ && w_rt != RT_BGEZ;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: o_ext_op = EXT_SIGN;
         OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_ri = 1'b0;
         // only mfc0, mtc0 and the exact eret word are legal in COP0 space
         OP_COP0: o_ri = !(o_eret || w_rs == RS_MFC0 || w_rs == RS_MTC0);
         default: o_ri = 1'b1;
      endcase
   end
endmodule

// File: rtl/if_id_decode.sv
// if_id_decode: IF/ID pipeline register with early immediate decode, exception merge, stall and flush
module if_id_decode
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC4 = 32'h0000_3004
) (
   input logic          clk,
   input logic          rst,
   if_id_decode_if.slave bus
);
   ext_op_e     w_ext_op;
   logic        w_ri, w_eret;
   logic [31:0] r_instr, r_pc4;
   logic [1:0]  r_ext_op;
   logic [4:0]  r_exc;
   logic        r_bd, r_eret, r_valid;

   instr_predecode u_predecode (
      .i_instr  (bus.Instr_F),
      .o_ext_op (w_ext_op),
      .o_ri     (w_ri),
      .o_eret   (w_eret)
   );

   // a bubble is sll $0,$0,0, so its ExtOp is the shamt mode; PC4 is kept for EPC use
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr  <= '0;
         r_pc4    <= RESET_PC4;
         r_ext_op <= EXT_SHAMT;
         r_exc    <= EXC_NONE;
         r_bd     <= 1'b0;
         r_eret   <= 1'b0;
         r_valid  <= 1'b0;
      end else if (bus.Flush) begin
         r_instr  <= '0;
         r_ext_op <= EXT_SHAMT;
         r_exc    <= EXC_NONE;
         r_bd     <= 1'b0;
         r_eret   <= 1'b0;
         r_valid  <= 1'b0;
      end else if (!bus.Stall) begin
         r_instr  <= bus.Instr_F;
         r_pc4    <= bus.PC4_F;
         r_ext_op <= w_ext_op;
         r_exc    <= (bus.ExcCode_F != EXC_NONE) ? bus.ExcCode_F : (w_ri ? EXC_RI : EXC_NONE);
         r_bd     <= bus.BD_F;
         r_eret   <= w_eret;
         r_valid  <= 1'b1;
      end
   end

   assign bus.Instr_D   = r_instr;
   assign bus.PC4_D     = r_pc4;
   assign bus.Imm16_D   = r_instr[15:0];
   assign bus.Imm26_D   = r_instr[25:0];
   assign bus.Rs_D      = r_instr[25:21];
   assign bus.Rt_D      = r_instr[20:16];
   assign bus.Rd_D      = r_instr[15:11];
   assign bus.ExtOp_D   = r_ext_op;
   assign bus.ExcCode_D = r_exc;
   assign bus.BD_D      = r_bd;
   assign bus.Eret_D    = r_eret;
   assign bus.Valid_D   = r_valid;
endmodule
